axi_lite_slave_regs: RTL

AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

---
 rtl/axi_lite_pkg.sv | 19 +
 rtl/axi_lite_regfile.sv | 38 +++
 rtl/axi_lite_slave_regs.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared constants and types for the AXI4-Lite register slave.
package axi_lite_pkg;
  localparam int NUM_REGS = 8;
  localparam int NUM_RW   = NUM_REGS - 1;
  localparam int IDX_W    = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    byte_merge = old_v;
    for (int i = 0; i < 4; i++)
      if (strb[i]) byte_merge[8*i +: 8] = new_v[8*i +: 8];
  endfunction
endpackage

// File: rtl/axi_lite_regfile.sv
// Register storage: slots 0..NUM_RW-1 are writable, the last slot reads a constant ID.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [IDX_W-1:0]       waddr,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  input  logic [IDX_W-1:0]       raddr,
  output logic [31:0]            rdata,
  output logic [NUM_RW*32-1:0]   regs_o
);
  logic [NUM_RW-1:0][31:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_RW; i++)
      if (we && waddr == IDX_W'(i)) regs_d[i] = byte_merge(regs_q[i], wdata, wstrb);
  end

  // Read is combinational from the current flops, so a same-edge write is not visible.
  always_comb begin
    rdata = ID_VALUE;
    for (int i = 0; i < NUM_RW; i++)
      if (raddr == IDX_W'(i)) rdata = regs_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  assign regs_o = regs_q;
endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave with 7 RW registers and one RO ID register; AW/W buffered independently.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 AWVALID,
  output logic                 AWREADY,
  input  logic [ADDR_W-1:0]    AWADDR,
  input  logic [2:0]           AWPROT,
  input  logic                 WVALID,
  output logic                 WREADY,
  input  logic [31:0]          WDATA,
  input  logic [3:0]           WSTRB,
  output logic                 BVALID,
  input  logic                 BREADY,
  output logic [1:0]           BRESP,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  input  logic [ADDR_W-1:0]    ARADDR,
  input  logic [2:0]           ARPROT,
  output logic                 RVALID,
  input  logic                 RREADY,
  output logic [31:0]          RDATA,
  output logic [1:0]           RRESP,
  output logic [NUM_RW*32-1:0] o_regs
);
  logic             rdy_en_q, rdy_en_d;
  logic             aw_full_q, aw_full_d, aw_oor_q, aw_oor_d;
  logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
  logic             w_full_q, w_full_d;
  logic [31:0]      w_data_q, w_data_d;
  logic [3:0]       w_strb_q, w_strb_d;
  wstate_e          wstate_q, wstate_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;

  logic             commit, wr_ok, ar_oor;
  logic [31:0]      rf_rdata;
  logic             unused_ok;

  assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

  // rdy_en_q holds every READY low through reset and for the release cycle.
  assign BVALID  = (wstate_q == W_RESP);
  assign AWREADY = rdy_en_q && !aw_full_q && !BVALID;
  assign WREADY  = rdy_en_q && !w_full_q && !BVALID;
  assign ARREADY = rdy_en_q && !rvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  assign commit = aw_full_q && w_full_q;
  assign wr_ok  = !aw_oor_q && (aw_idx_q != IDX_W'(NUM_REGS - 1));
  assign ar_oor = |(ARADDR >> 5);

  always_comb begin
    rdy_en_d  = 1'b1;
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    aw_oor_d  = aw_oor_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    wstate_d  = wstate_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (AWVALID && AWREADY) begin
      aw_full_d = 1'b1;
      aw_idx_d  = AWADDR[4:2];
      aw_oor_d  = |(AWADDR >> 5);
    end
    if (WVALID && WREADY) begin
      w_full_d = 1'b1;
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end

    case (wstate_q)
      W_IDLE: if (commit) begin
        aw_full_d = 1'b0;
        w_full_d  = 1'b0;
        wstate_d  = W_RESP;
        bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
      W_RESP: if (BREADY) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase

    if (ARVALID && ARREADY) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_oor ? 32'h0 : rf_rdata;
      rresp_d  = ar_oor ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdy_en_q  <= 1'b0;
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_oor_q  <= 1'b0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      wstate_q  <= W_IDLE;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rdy_en_q  <= rdy_en_d;
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      aw_oor_q  <= aw_oor_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      wstate_q  <= wstate_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  axi_lite_regfile #(.ID_VALUE(ID_VALUE)) u_regfile (
    .clk    (ACLK),
    .rst    (ARESET),
    .we     (commit && wr_ok),
    .waddr  (aw_idx_q),
    .wdata  (w_data_q),
    .wstrb  (w_strb_q),
    .raddr  (ARADDR[4:2]),
    .rdata  (rf_rdata),
    .regs_o (o_regs)
  );
endmodule
